mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 204 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : MIPS memory stage. Resolves the branch, runs a req/ack data port
//             with stall and ack timeout, and owns the MEM/WB register.
//             Optional MEM_MISALIGN_CHECK_EN suppresses misaligned accesses.
// Revision  : 1.0
// ============================================================================
module mem_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Branch_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  input  logic        zero_in,
  input  logic [4:0]  Destination_in,
  input  logic [31:0] branchAdd_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] Rt_Data_in,
  output logic        PCSrc,
  output logic [31:0] branchTarget,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        MemToReg_out,
  output logic        RegWrite_out,
  output logic [4:0]  Destination_out,
  output logic [31:0] ALUresult_out,
  output logic [31:0] ReadData_out,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // The timeout cycle is the last WAIT cycle, so req is high ACK_TIMEOUT cycles in total.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 2);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        lat_we_q, lat_we_d, lat_m2r_q, lat_m2r_d, lat_rw_q, lat_rw_d;
  logic [4:0]  lat_dest_q, lat_dest_d;
  logic [31:0] lat_addr_q, lat_addr_d, lat_wdata_q, lat_wdata_d;
  logic        wb_m2r_q, wb_m2r_d, wb_rw_q, wb_rw_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;
  logic        bus_err_q, bus_err_d, misalign_q, misalign_d;
  logic        req_c, we_c, stall_c, pcsrc_c;
  logic [31:0] addr_c, wdata_c;
  logic        access_w, misal_w;

  assign access_w = MemRead_in | MemWrite_in;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misal_w = access_w & (ALUresult_in[1:0] != 2'b00);
`else
  assign misal_w = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_m2r_d   = lat_m2r_q;
    lat_rw_d    = lat_rw_q;
    lat_dest_d  = lat_dest_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    wb_m2r_d    = 1'b0;
    wb_rw_d     = 1'b0;
    wb_dest_d   = 5'd0;
    wb_alu_d    = 32'd0;
    wb_rdata_d  = 32'd0;
    bus_err_d   = bus_err_q;
    misalign_d  = 1'b0;
    req_c       = 1'b0;
    we_c        = 1'b0;
    stall_c     = 1'b0;
    pcsrc_c     = 1'b0;
    addr_c      = ALUresult_in;
    wdata_c     = Rt_Data_in;

    case (state_q)
      IDLE: begin
        pcsrc_c = Branch_in & zero_in;
        if (misal_w) begin
          wb_dest_d  = Destination_in;
          wb_alu_d   = ALUresult_in;
          misalign_d = 1'b1;
        end else if (access_w) begin
          req_c = 1'b1;
          we_c  = MemWrite_in;
          if (dmem_ack) begin
            wb_m2r_d   = MemToReg_in;
            wb_rw_d    = RegWrite_in;
            wb_dest_d  = Destination_in;
            wb_alu_d   = ALUresult_in;
            wb_rdata_d = MemWrite_in ? 32'd0 : dmem_rdata;
          end else begin
            stall_c     = 1'b1;
            lat_we_d    = MemWrite_in;
            lat_m2r_d   = MemToReg_in;
            lat_rw_d    = RegWrite_in;
            lat_dest_d  = Destination_in;
            lat_addr_d  = ALUresult_in;
            lat_wdata_d = Rt_Data_in;
            cnt_d       = 8'd0;
            state_d     = WAIT;
          end
        end else begin
          wb_m2r_d  = MemToReg_in;
          wb_rw_d   = RegWrite_in;
          wb_dest_d = Destination_in;
          wb_alu_d  = ALUresult_in;
        end
      end
      WAIT: begin
        req_c   = 1'b1;
        we_c    = lat_we_q;
        addr_c  = lat_addr_q;
        wdata_c = lat_wdata_q;
        if (dmem_ack) begin
          wb_m2r_d   = lat_m2r_q;
          wb_rw_d    = lat_rw_q;
          wb_dest_d  = lat_dest_q;
          wb_alu_d   = lat_addr_q;
          wb_rdata_d = lat_we_q ? 32'd0 : dmem_rdata;
          state_d    = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Aborted access retires with write-back suppressed.
          wb_dest_d = lat_dest_q;
          wb_alu_d  = lat_addr_q;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      lat_we_q    <= 1'b0;
      lat_m2r_q   <= 1'b0;
      lat_rw_q    <= 1'b0;
      lat_dest_q  <= 5'd0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 32'd0;
      wb_m2r_q    <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_dest_q   <= 5'd0;
      wb_alu_q    <= 32'd0;
      wb_rdata_q  <= 32'd0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_m2r_q   <= lat_m2r_d;
      lat_rw_q    <= lat_rw_d;
      lat_dest_q  <= lat_dest_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      wb_m2r_q    <= wb_m2r_d;
      wb_rw_q     <= wb_rw_d;
      wb_dest_q   <= wb_dest_d;
      wb_alu_q    <= wb_alu_d;
      wb_rdata_q  <= wb_rdata_d;
      bus_err_q   <= bus_err_d;
      misalign_q  <= misalign_d;
    end
  end

  // Handshake and hazard outputs are gated so reset silences them without a clock.
  assign dmem_req        = rst & req_c;
  assign dmem_we         = rst & req_c & we_c;
  assign stall           = rst & stall_c;
  assign PCSrc           = rst & pcsrc_c;
  assign dmem_addr       = addr_c;
  assign dmem_wdata      = wdata_c;
  assign branchTarget    = branchAdd_in;
  assign MemToReg_out    = wb_m2r_q;
  assign RegWrite_out    = wb_rw_q;
  assign Destination_out = wb_dest_q;
  assign ALUresult_out   = wb_alu_q;
  assign ReadData_out    = wb_rdata_q;
  assign bus_err         = bus_err_q;
  assign misalign        = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : randomized self-checking bench for mem_stage against a
//                transaction-level model of the memory stage.
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        Branch_in, MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in, zero_in;
  logic [4:0]  Destination_in;
  logic [31:0] branchAdd_in, ALUresult_in, Rt_Data_in;
  logic        PCSrc, stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] branchTarget, dmem_addr, dmem_wdata, dmem_rdata;
  logic        MemToReg_out, RegWrite_out, bus_err, misalign;
  logic [4:0]  Destination_out;
  logic [31:0] ALUresult_out, ReadData_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_bus_err = 1'b0;

  typedef struct {
    logic        br, mw, mr, m2r, rw, zr;
    logic [4:0]  dest;
    logic [31:0] badd, alu, rt, rdata;
    int          delay;  // ack cycle offset; negative means never acked
  } txn_t;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .Branch_in(Branch_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .zero_in(zero_in),
    .Destination_in(Destination_in), .branchAdd_in(branchAdd_in),
    .ALUresult_in(ALUresult_in), .Rt_Data_in(Rt_Data_in),
    .PCSrc(PCSrc), .branchTarget(branchTarget), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out),
    .Destination_out(Destination_out), .ALUresult_out(ALUresult_out),
    .ReadData_out(ReadData_out), .bus_err(bus_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [70:0] wb_now();
    return {MemToReg_out, RegWrite_out, Destination_out, ALUresult_out, ReadData_out};
  endfunction

  task automatic drive(input txn_t t);
    Branch_in = t.br;  MemWrite_in = t.mw;  MemRead_in = t.mr;
    MemToReg_in = t.m2r;  RegWrite_in = t.rw;  zero_in = t.zr;
    Destination_in = t.dest;  branchAdd_in = t.badd;
    ALUresult_in = t.alu;  Rt_Data_in = t.rt;
  endtask

  task automatic drive_junk();
    Branch_in = 1'($urandom);  MemWrite_in = 1'($urandom);  MemRead_in = 1'($urandom);
    MemToReg_in = 1'($urandom);  RegWrite_in = 1'($urandom);  zero_in = 1'($urandom);
    Destination_in = 5'($urandom);  branchAdd_in = $urandom;
    ALUresult_in = $urandom & 32'hFFFF_FFFC;  Rt_Data_in = $urandom;
  endtask

  function automatic txn_t mk(input logic mr, input logic mw, input logic [31:0] alu,
                              input logic [31:0] rt, input logic [31:0] rdata, input int delay);
    txn_t t;
    t.br = 1'b0; t.zr = 1'b0; t.mr = mr; t.mw = mw; t.m2r = mr; t.rw = 1'b1;
    t.dest = 5'd9; t.badd = 32'h0; t.alu = alu; t.rt = rt; t.rdata = rdata; t.delay = delay;
    return t;
  endfunction

  // Runs one stage transaction cycle by cycle and checks it against the model:
  // an access occupies delay+1 cycles (or TO cycles without ack), stalls in all
  // but its last cycle, and retires one entry after its last cycle.
  task automatic do_txn(input txn_t t);
    logic access, tmo;
    int n;
    logic [70:0] exp_wb;
    access = t.mw | t.mr;
    tmo = access && (t.delay < 0);
    n = !access ? 1 : (tmo ? TO : t.delay + 1);
    for (int c = 0; c < n; c++) begin
      if (c == 0) drive(t); else drive_junk();
      if (access) dmem_ack = !tmo && (c == t.delay);
      else dmem_ack = 1'($urandom);
      dmem_rdata = (access && dmem_ack) ? t.rdata : $urandom;
      #1;
      n_checks++;
      if (dmem_req !== access) begin
        n_fail++; $display("FAIL req c=%0d: got %b expected %b", c, dmem_req, access);
      end
      n_checks++;
      if (stall !== (access && c != n - 1)) begin
        n_fail++; $display("FAIL stall c=%0d: got %b expected %b", c, stall, access && c != n - 1);
      end
      n_checks++;
      if (PCSrc !== ((c == 0) ? (t.br & t.zr) : 1'b0)) begin
        n_fail++; $display("FAIL pcsrc c=%0d: got %b", c, PCSrc);
      end
      n_checks++;
      if (branchTarget !== branchAdd_in) begin
        n_fail++; $display("FAIL branch_target: got %h expected %h", branchTarget, branchAdd_in);
      end
      if (access) begin
        n_checks++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {t.mw, t.alu, t.rt}) begin
          n_fail++;
          $display("FAIL port c=%0d: got we=%b a=%h d=%h expected we=%b a=%h d=%h",
                   c, dmem_we, dmem_addr, dmem_wdata, t.mw, t.alu, t.rt);
        end
      end
      @(posedge clk); #1;
      if (c == n - 1) begin
        if (tmo) exp_bus_err = 1'b1;
        exp_wb = tmo ? {2'b00, t.dest, t.alu, 32'h0}
                     : {t.m2r, t.rw, t.dest, t.alu, (access && !t.mw) ? t.rdata : 32'h0};
      end else begin
        exp_wb = '0;
      end
      n_checks++;
      if (wb_now() !== exp_wb) begin
        n_fail++; $display("FAIL memwb c=%0d: got %h expected %h", c, wb_now(), exp_wb);
      end
      n_checks++;
      if ({bus_err, misalign} !== {exp_bus_err, 1'b0}) begin
        n_fail++;
        $display("FAIL flags c=%0d: got bus_err=%b misalign=%b expected %b 0", c, bus_err, misalign, exp_bus_err);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(mk(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 0));
    Branch_in = 1'b1; zero_in = 1'b1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #2;
    n_checks++;
    if ({dmem_req, dmem_we, stall, PCSrc} !== 4'b0) begin
      n_fail++; $display("FAIL reset_comb: got %b expected 0000", {dmem_req, dmem_we, stall, PCSrc});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({wb_now(), bus_err, misalign} !== '0) begin
      n_fail++; $display("FAIL reset_regs: got %h expected 0", {wb_now(), bus_err, misalign});
    end
    drive(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait_load();
    do_txn(mk(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0));
  endtask

  task automatic test_store_wait();
    do_txn(mk(1'b0, 1'b1, 32'h10, 32'h1234, 32'h5555_AAAA, 3));
    do_txn(mk(1'b1, 1'b1, 32'h20, 32'h77, 32'h1111_2222, 1));
  endtask

  task automatic test_branch();
    txn_t t;
    t = mk(1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 0);
    t.br = 1'b1; t.zr = 1'b1; t.badd = 32'h100;
    do_txn(t);
    t.zr = 1'b0;
    do_txn(t);
    // Branch asserted alongside a stalled load: only the first cycle resolves it.
    t = mk(1'b1, 1'b0, 32'h80, 32'h0, 32'hCAFE_0001, 2);
    t.br = 1'b1; t.zr = 1'b1; t.badd = 32'h200;
    do_txn(t);
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
    drive(mk(1'b1, 1'b0, 32'h42, 32'h0, 32'h0, 0));
    dmem_ack = 1'b0;
    #1;
    n_checks++;
    if ({dmem_req, stall} !== 2'b00) begin
      n_fail++; $display("FAIL misalign_issue: got req/stall %b expected 00", {dmem_req, stall});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({wb_now(), misalign} !== {2'b00, 5'd9, 32'h42, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL misalign_entry: got %h misalign=%b", wb_now(), misalign);
    end
    drive(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0));
    @(posedge clk); #1;
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++; $display("FAIL misalign_pulse: got %b expected 0", misalign);
    end
`else
    do_txn(mk(1'b1, 1'b0, 32'h42, 32'h0, 32'h0BAD_F00D, 0));
`endif
  endtask

  task automatic test_timeout();
    do_txn(mk(1'b1, 1'b0, 32'h44, 32'h0, 32'h0, -1));
    // Ack on the timeout cycle still completes normally.
    do_txn(mk(1'b1, 1'b0, 32'h48, 32'h0, 32'h1357_9BDF, TO - 1));
  endtask

  task automatic test_back_to_back_random(input int count);
    txn_t t;
    for (int i = 0; i < count; i++) begin
      drive_junk();
      t.br = Branch_in; t.zr = zero_in; t.m2r = MemToReg_in; t.rw = RegWrite_in;
      t.dest = Destination_in; t.badd = branchAdd_in; t.alu = ALUresult_in;
      t.rt = Rt_Data_in; t.rdata = $urandom;
      case ($urandom_range(0, 3))
        0: begin t.mr = 1'b0; t.mw = 1'b0; end
        1: begin t.mr = 1'b1; t.mw = 1'b0; end
        2: begin t.mr = 1'b0; t.mw = 1'b1; end
        default: begin t.mr = 1'b1; t.mw = 1'b1; end
      endcase
      t.delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      do_txn(t);
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(mk(1'b1, 1'b0, 32'h60, 32'h0, 32'h0, 0));
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    drive_junk();
    Branch_in = 1'b1; zero_in = 1'b1; MemRead_in = 1'b1;
    #2 rst = 1'b0;
    exp_bus_err = 1'b0;
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, stall, PCSrc} !== 4'b0) begin
      n_fail++; $display("FAIL midwait_comb: got %b expected 0000", {dmem_req, dmem_we, stall, PCSrc});
    end
    n_checks++;
    if ({wb_now(), bus_err, misalign} !== '0) begin
      n_fail++; $display("FAIL midwait_regs: got %h expected 0", {wb_now(), bus_err, misalign});
    end
    drive(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    do_txn(mk(1'b1, 1'b0, 32'h64, 32'h0, 32'h2468_ACE0, 1));
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_branch();
    test_misalign();
    test_timeout();
    test_back_to_back_random(40);
    test_reset_mid_wait();
    test_back_to_back_random(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
